// File: rtl/cpu7_ifu_ibuf_pkg.sv
// Shared types and constants for the cpu7 IFU instruction buffer.
// Defines the buffer entry layout, the exception-slot instruction word and the group length rule.
package cpu7_ifu_ibuf_pkg;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int EXC_W  = 6;
  localparam int LANES  = 4;

  // Exception entries carry no instruction bits.
  localparam logic [INST_W-1:0] EX_INST = 32'h0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              ex;
    logic [EXC_W-1:0]  exccode;
  } entry_t;

  // Number of entries a fetch group produces: a faulting group always collapses to one.
  function automatic logic [2:0] group_len(input logic ex, input logic [1:0] count);
    return ex ? 3'd1 : ({1'b0, count} + 3'd1);
  endfunction

endpackage

// File: rtl/cpu7_ifu_ibuf_wsel.sv
// Lane select for the instruction buffer: maps a fetch group onto per-slot write enables and data.
// Also presents the group's first instruction so the top level can bypass it to decode.
module cpu7_ifu_ibuf_wsel
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   en,
  input  logic [AW-1:0]          wptr,
  input  logic [31:0]            pc,
  input  logic [127:0]           rdata,
  input  logic [1:0]             count,
  input  logic                   ex,
  input  logic [5:0]             exccode,
  input  logic                   skip,
  output logic [DEPTH-1:0]       we,
  output entry_t [DEPTH-1:0]     wdata,
  output entry_t                 first,
  output logic [2:0]             push_n
);

  logic [2:0]    len;
  logic [1:0]    lane;
  logic [AW-1:0] slot;
  entry_t        ent;

  assign len    = group_len(ex, count);
  assign push_n = en ? (len - {2'b00, skip}) : 3'd0;

  // NOTE: every variable driven here gets a default before the loop, so no path leaves one holding state.
  always_comb begin
    we    = '0;
    wdata = '0;
    first = '0;
    lane  = '0;
    slot  = '0;
    ent   = '0;
    for (int j = 0; j < LANES; j++) begin
      lane        = pc[3:2] + 2'(j);
      ent.pc      = pc + 32'(j * 4);
      ent.inst    = ex ? EX_INST : rdata[{lane, 5'b00000} +: 32];
      ent.ex      = ex;
      ent.exccode = ex ? exccode : '0;
      if (j == 0) first = ent;
      // A bypassed first instruction shifts the rest of the group down one slot.
      slot = wptr + AW'(j) - AW'(skip);
      if (en && (3'(j) < len) && (j >= int'(skip))) begin
        we[slot]    = 1'b1;
        wdata[slot] = ent;
      end
    end
  end

endmodule

// File: rtl/cpu7_ifu_ibuf.sv
// cpu7 IFU instruction buffer: queues 1-4 instruction fetch groups and issues one per cycle to decode.
// Optional same-cycle empty-buffer bypass is enabled by defining CPU7_IBUF_BYPASS_EN.
module cpu7_ifu_ibuf
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             br_cancel,
  input  logic             fch_ibuf_valid,
  input  logic [31:0]      fch_ibuf_pc,
  input  logic [127:0]     fch_ibuf_rdata,
  input  logic [1:0]       fch_ibuf_count,
  input  logic             fch_ibuf_ex,
  input  logic [5:0]       fch_ibuf_exccode,
  output logic             ibuf_fch_ready,
  output logic             ibuf_dec_valid,
  output logic [31:0]      ibuf_dec_pc,
  output logic [31:0]      ibuf_dec_inst,
  output logic             ibuf_dec_ex,
  output logic [5:0]       ibuf_dec_exccode,
  input  logic             dec_ibuf_ready,
  output logic [CNT_W-1:0] ibuf_cnt
);

  localparam int AW = $clog2(DEPTH);

  entry_t               mem [DEPTH];
  logic [AW-1:0]        rptr;
  logic [AW-1:0]        wptr;
  logic [CNT_W-1:0]     cnt;

  logic                 push;
  logic                 pop;
  logic                 skip;
  logic [2:0]           push_n;
  logic [DEPTH-1:0]     we;
  entry_t [DEPTH-1:0]   wdata;
  entry_t               first;
  entry_t               head;

  // Room for a worst-case group is judged on registered occupancy only.
  assign ibuf_fch_ready = ~reset & (cnt <= CNT_W'(DEPTH - 4));
  assign push           = fch_ibuf_valid & ibuf_fch_ready & ~br_cancel;

`ifdef CPU7_IBUF_BYPASS_EN
  logic bypass;
  assign bypass         = push & (cnt == '0);
  assign skip           = bypass & dec_ibuf_ready;
  assign ibuf_dec_valid = ((cnt != '0) | bypass) & ~br_cancel;
  assign head           = bypass ? first : mem[rptr];
`else
  logic unused_first;
  assign unused_first   = ^first;
  assign skip           = 1'b0;
  assign ibuf_dec_valid = (cnt != '0) & ~br_cancel;
  assign head           = mem[rptr];
`endif

  // Only stored entries advance the read pointer; a bypassed instruction never lands in storage.
  assign pop = ibuf_dec_valid & dec_ibuf_ready & (cnt != '0);

  assign ibuf_dec_pc      = ibuf_dec_valid ? head.pc      : '0;
  assign ibuf_dec_inst    = ibuf_dec_valid ? head.inst    : '0;
  assign ibuf_dec_ex      = ibuf_dec_valid ? head.ex      : 1'b0;
  assign ibuf_dec_exccode = ibuf_dec_valid ? head.exccode : '0;
  assign ibuf_cnt         = cnt;

  cpu7_ifu_ibuf_wsel #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wsel (
    .en      (push),
    .wptr    (wptr),
    .pc      (fch_ibuf_pc),
    .rdata   (fch_ibuf_rdata),
    .count   (fch_ibuf_count),
    .ex      (fch_ibuf_ex),
    .exccode (fch_ibuf_exccode),
    .skip    (skip),
    .we      (we),
    .wdata   (wdata),
    .first   (first),
    .push_n  (push_n)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || br_cancel) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr + AW'(push_n);
      rptr <= rptr + AW'(pop);
      cnt  <= cnt + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  // NOTE: entry storage has no reset; cnt alone decides which slots are meaningful.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we[i]) mem[i] <= wdata[i];
    end
  end

  a_lane_fit: assert property (@(posedge clock) disable iff (reset)
    (push && !fch_ibuf_ex) |-> (({1'b0, fch_ibuf_pc[3:2]} + {1'b0, fch_ibuf_count}) <= 3'd3));

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Scoreboard bench for cpu7_ifu_ibuf: stimulus pushes expected instructions, a monitor checks issue.
// Follows CPU7_IBUF_BYPASS_EN the same way the design does.
`timescale 1ns/1ps
module tb_cpu7_ifu_ibuf;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             br_cancel;
  logic             fch_ibuf_valid;
  logic [31:0]      fch_ibuf_pc;
  logic [127:0]     fch_ibuf_rdata;
  logic [1:0]       fch_ibuf_count;
  logic             fch_ibuf_ex;
  logic [5:0]       fch_ibuf_exccode;
  logic             ibuf_fch_ready;
  logic             ibuf_dec_valid;
  logic [31:0]      ibuf_dec_pc;
  logic [31:0]      ibuf_dec_inst;
  logic             ibuf_dec_ex;
  logic [5:0]       ibuf_dec_exccode;
  logic             dec_ibuf_ready;
  logic [CNT_W-1:0] ibuf_cnt;

  always #5 clock = ~clock;

  cpu7_ifu_ibuf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .br_cancel        (br_cancel),
    .fch_ibuf_valid   (fch_ibuf_valid),
    .fch_ibuf_pc      (fch_ibuf_pc),
    .fch_ibuf_rdata   (fch_ibuf_rdata),
    .fch_ibuf_count   (fch_ibuf_count),
    .fch_ibuf_ex      (fch_ibuf_ex),
    .fch_ibuf_exccode (fch_ibuf_exccode),
    .ibuf_fch_ready   (ibuf_fch_ready),
    .ibuf_dec_valid   (ibuf_dec_valid),
    .ibuf_dec_pc      (ibuf_dec_pc),
    .ibuf_dec_inst    (ibuf_dec_inst),
    .ibuf_dec_ex      (ibuf_dec_ex),
    .ibuf_dec_exccode (ibuf_dec_exccode),
    .dec_ibuf_ready   (dec_ibuf_ready),
    .ibuf_cnt         (ibuf_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  exc;
  } exp_t;

  exp_t exp_q[$];   // instructions the buffer should be holding, oldest first
  exp_t pend_q[$];  // accepted this cycle, become visible after the next edge
  bit   pend_cancel = 1'b0;
  bit   byp_now     = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expand a fetch group into the instruction sequence it stands for.
  task automatic add_group(input bit now, input logic [31:0] pc, input logic [127:0] rd,
                           input logic [1:0] cm1, input logic ex, input logic [5:0] exc);
    exp_t e;
    int   lane;
    if (ex) begin
      e.pc = pc; e.inst = 32'h0; e.ex = 1'b1; e.exc = exc;
      if (now) exp_q.push_back(e); else pend_q.push_back(e);
    end else begin
      for (int k = 0; k <= int'(cm1); k++) begin
        lane  = int'(pc[3:2]) + k;
        e.pc  = pc + 32'(4 * k);
        e.inst = rd[32 * lane +: 32];
        e.ex  = 1'b0;
        e.exc = 6'h0;
        if (now) exp_q.push_back(e); else pend_q.push_back(e);
      end
    end
  endtask

  // Model commit: what was accepted last cycle is now stored; cancel and reset empty the buffer.
  initial begin
    forever begin
      @(posedge clock);
      if (reset || pend_cancel) exp_q.delete();
      else foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
      pend_cancel = 1'b0;
      byp_now     = 1'b0;
    end
  end

  // Monitor: compares the decode-side outputs with the model every cycle and retires issued entries.
  initial begin
    exp_t e;
    bit   ev;
    int   ec;
    forever begin
      @(negedge clock);
      ev = (exp_q.size() != 0) && !br_cancel;
      ec = byp_now ? 0 : exp_q.size();
      check("dec_valid", ibuf_dec_valid, ev);
      check("cnt", ibuf_cnt, ec);
      if (ev) begin
        e = exp_q[0];
        check("head", {ibuf_dec_pc, ibuf_dec_inst, ibuf_dec_ex, ibuf_dec_exccode},
              {e.pc, e.inst, e.ex, e.exc});
        if (dec_ibuf_ready) void'(exp_q.pop_front());
      end else begin
        check("idle_out", {ibuf_dec_pc, ibuf_dec_inst, ibuf_dec_ex, ibuf_dec_exccode}, '0);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [127:0] rd,
                       input logic [1:0] cm1, input logic ex, input logic [5:0] exc,
                       input logic rdy, input logic cancel);
    bit exp_ready;
    @(posedge clock);
    #1;
    fch_ibuf_valid   = v;
    fch_ibuf_pc      = pc;
    fch_ibuf_rdata   = rd;
    fch_ibuf_count   = cm1;
    fch_ibuf_ex      = ex;
    fch_ibuf_exccode = exc;
    dec_ibuf_ready   = rdy;
    br_cancel        = cancel;
    #1;
    exp_ready = !reset && (exp_q.size() <= DEPTH - 4);
    check("fch_ready", ibuf_fch_ready, exp_ready);
    pend_cancel = cancel;
    if (v && exp_ready && !cancel) begin
`ifdef CPU7_IBUF_BYPASS_EN
      if (exp_q.size() == 0) begin
        byp_now = 1'b1;
        add_group(1'b1, pc, rd, cm1, ex, exc);
      end else begin
        add_group(1'b0, pc, rd, cm1, ex, exc);
      end
`else
      add_group(1'b0, pc, rd, cm1, ex, exc);
`endif
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 128'h0, 2'd0, 1'b0, 6'h0, rdy, 1'b0);
  endtask

  localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] LINE_B = {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000};

  initial begin
    logic [31:0]  r;
    logic [31:0]  rpc;
    logic [127:0] rd;
    int           l;
    int           c;

    reset = 1'b1; br_cancel = 1'b0; fch_ibuf_valid = 1'b0; fch_ibuf_pc = '0;
    fch_ibuf_rdata = '0; fch_ibuf_count = '0; fch_ibuf_ex = 1'b0; fch_ibuf_exccode = '0;
    dec_ibuf_ready = 1'b0;

    // Reset: ready held low, buffer empty.
    idle(3, 1'b0);
    reset = 1'b0;
    idle(1, 1'b0);

    // Aligned four-wide group, issued back to back.
    drive(1'b1, 32'h1c000000, LINE_A, 2'd3, 1'b0, 6'h0, 1'b1, 1'b0);
    idle(1, 1'b1);
    @(negedge clock);
`ifndef CPU7_IBUF_BYPASS_EN
    check("t1_first_inst", ibuf_dec_inst, 32'h11);
    check("t1_first_pc", ibuf_dec_pc, 32'h1c000000);
`endif
    idle(4, 1'b1);
    @(negedge clock);
    check("t1_cnt_empty", ibuf_cnt, 0);

    // Group starting at lane 2.
    drive(1'b1, 32'h1c000008, LINE_B, 2'd1, 1'b0, 6'h0, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clock);
    check("t2_cnt", ibuf_cnt, 2);
    check("t2_inst", ibuf_dec_inst, 32'hcccc0002);
    check("t2_pc", ibuf_dec_pc, 32'h1c000008);
    idle(3, 1'b1);

    // Fill to DEPTH, hold a group while full, then drain until ready returns.
    drive(1'b1, 32'h1c000100, LINE_A, 2'd3, 1'b0, 6'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h1c000110, LINE_B, 2'd3, 1'b0, 6'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h1c000120, LINE_A, 2'd3, 1'b0, 6'h0, 1'b0, 1'b0);
    @(negedge clock);
    check("t3_full_cnt", ibuf_cnt, 8);
    check("t3_full_ready", ibuf_fch_ready, 1'b0);
    drive(1'b1, 32'h1c000120, LINE_A, 2'd3, 1'b0, 6'h0, 1'b0, 1'b0);
    idle(4, 1'b1);
    idle(1, 1'b0);
    @(negedge clock);
    check("t3_ready_back", ibuf_fch_ready, 1'b1);
    check("t3_cnt4", ibuf_cnt, 4);

    // Branch cancel with a simultaneous push at cnt=5.
    drive(1'b1, 32'h1c000200, LINE_B, 2'd0, 1'b0, 6'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h1c000300, LINE_A, 2'd3, 1'b0, 6'h0, 1'b1, 1'b1);
    @(negedge clock);
    check("t4_cancel_valid", ibuf_dec_valid, 1'b0);
    idle(1, 1'b0);
    @(negedge clock);
    check("t4_flushed_cnt", ibuf_cnt, 0);

    // Exception group collapses to a single entry.
    drive(1'b1, 32'h1c000404, LINE_B, 2'd3, 1'b1, 6'h08, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(negedge clock);
    check("t5_cnt", ibuf_cnt, 1);
    check("t5_inst", ibuf_dec_inst, 32'h0);
    check("t5_ex", ibuf_dec_ex, 1'b1);
    check("t5_exccode", ibuf_dec_exccode, 6'h08);
    idle(2, 1'b1);

    // Random traffic: legal groups, random decode back-pressure, occasional cancel.
    for (int i = 0; i < 300; i++) begin
      l   = $urandom_range(0, 3);
      c   = $urandom_range(0, 3 - l);
      r   = $urandom();
      rpc = {r[31:4], 2'(l), 2'b00};
      rd  = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive($urandom_range(0, 3) != 0, rpc, rd, 2'(c), $urandom_range(0, 9) == 0,
            6'($urandom_range(0, 63)), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && pend_q.size() == 0) break;
      idle(1, 1'b1);
    end
    check("drain_empty", exp_q.size() + pend_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_ibuf.md
Name: cpu7_ifu_ibuf

Overview:
Instruction buffer between the instruction-bus response path and the decode stage of the cpu7 IFU.
- Accepts fetch groups of 1–4 instructions per cycle from the 128-bit fetch response.
- Queues them with PC and exception info.
- Issues one instruction per cycle to decode under valid/ready handshake.
- Flushes on branch cancel from the EXU.

Parameters:
DEPTH, 8, number of instruction entries; power of 2, >= 4.
CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
br_cancel  in  1  EXU branch cancel; flush buffer
fch_ibuf_valid  in  1  fetch group valid
fch_ibuf_pc  in  32  PC of first instruction of group
fch_ibuf_rdata  in  128  fetch line; lane i = rdata[32i+31:32i]
fch_ibuf_count  in  2  valid instructions in group minus 1
fch_ibuf_ex  in  1  fetch exception
fch_ibuf_exccode  in  6  exception code
ibuf_fch_ready  out  1  buffer can accept a full group
ibuf_dec_valid  out  1  head entry valid
ibuf_dec_pc  out  32  head PC
ibuf_dec_inst  out  32  head instruction
ibuf_dec_ex  out  1  head exception flag
ibuf_dec_exccode  out  6  head exception code
dec_ibuf_ready  in  1  decode consumes head this cycle
ibuf_cnt  out  CNT_W  current occupancy

Behaviour:
- Clock and reset: single clock `clock`; reset `reset` is synchronous, active-high.
- Reset state: rptr=0, wptr=0, cnt=0.
  - ibuf_dec_valid=0, ibuf_cnt=0.
  - ibuf_fch_ready=0 while reset is asserted, 1 the cycle after.
  - ibuf_dec_pc/inst/ex/exccode read 0 whenever ibuf_dec_valid=0.
- Entry storage: {pc[31:0], inst[31:0], ex, exccode[5:0]}. Storage registers are not reset.
- Ready rule: ibuf_fch_ready = ~reset & (cnt <= DEPTH-4). It depends on registered occupancy only, with no same-cycle pop credit.
- Push occurs on fch_ibuf_valid & ibuf_fch_ready & ~br_cancel. If fch_ibuf_valid is asserted while not ready, the group is dropped; the upstream must hold it.
- Normal group:
  - Lane alignment: first lane L = fch_ibuf_pc[3:2]; n = count+1.
  - Entry k (0..n-1) gets inst = lane L+k, pc = fch_ibuf_pc + 4k, ex=0.
  - L+count > 3 is illegal; the simulation assertion fires.
- Exception group (fch_ibuf_ex=1): exactly one entry is pushed, with inst=32'h0, pc=fch_ibuf_pc, ex=1, exccode=fch_ibuf_exccode. Count is ignored.
- Pop: ibuf_dec_valid = (cnt!=0) & ~br_cancel. Pop occurs on ibuf_dec_valid & dec_ibuf_ready; rptr+1.
- Update: cnt_next = cnt + push_n - pop. Pointers wrap modulo DEPTH. Simultaneous push and pop are both legal in one cycle.
- Latency: a pushed instruction is visible at the head at the earliest on the cycle after the push (unless the bypass feature is enabled).
- Flush: br_cancel=1 → next cycle rptr=wptr=0, cnt=0.
  - The same-cycle push is discarded.
  - ibuf_dec_valid is forced 0 in the cancel cycle.
  - br_cancel has priority over push, pop, and full.
- Reset overrides br_cancel.

Optional Feature:
CPU7_IBUF_BYPASS_EN
- Defined: when cnt==0 and a push occurs, the first instruction of the group drives ibuf_dec_* in the same cycle with ibuf_dec_valid=1.
  - If dec_ibuf_ready=1, that instruction is not written; n-1 entries are stored.
  - If dec_ibuf_ready=0, all n are stored.
  - br_cancel still suppresses the bypass.
- Undefined: minimum push-to-issue latency is 1 cycle, as described above.

Decomposition:
- common.vh: IBUF entry field widths and offsets, exception-instruction constant 32'h0.
- One sub-module: cpu7_ifu_ibuf_wsel, combinational lane select producing per-slot write enable and write data from wptr, L, n, and ex.
- Pointers, counter, handshake and bypass logic stay in cpu7_ifu_ibuf.

Test Plan:
1. Reset then push pc=0x1c000000, count=3, lanes 0x11/0x22/0x33/0x44, dec_ready=1 → issues 0x11@..00, 0x22@..04, 0x33@..08, 0x44@..0c on 4 consecutive cycles; cnt back to 0.
2. pc=0x1c000008, count=1 → entries {lane2 @..08, lane3 @..0c}; cnt=2.
3. Push 4 + 4 with dec_ready=0 → cnt=8, ibuf_fch_ready=0. Hold fch_ibuf_valid → no push. Pop 4 → ready returns when cnt=4.
4. cnt=5, br_cancel with simultaneous push → ibuf_dec_valid=0 that cycle; next cycle cnt=0 and the new group is lost.
5. fch_ibuf_ex=1, exccode=0x08, count=3 → single entry: inst=0, ex=1, exccode=0x08; cnt=1.
6. DEPTH=8 wrap: push/pop stream of 20 instructions with random dec_ready → in-order output, no loss; with CPU7_IBUF_BYPASS_EN, an empty-buffer push with dec_ready=1 issues the first instruction in the same cycle.
